// File: rtl/dmem_access_ctrl_pkg.sv
// Shared Y86-64 instruction/status encodings and memory-stage FSM states.
// Imported by the memory access controller and its operand decoder.
package dmem_access_ctrl_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_wr_op(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
  endfunction

  function automatic logic is_rd_op(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_op_decode.sv
// Combinational decode of icode/valE/valA into memory access attributes.
// Zero latency; no flow control of its own.
module dmem_op_decode
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic [3:0]        icode_i,
  input  logic [ADDR_W-1:0] val_e_i,
  input  logic [DATA_W-1:0] val_a_i,
  output logic              is_mem_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o
);

  always_comb begin
    we_o     = is_wr_op(icode_i);
    is_mem_o = is_wr_op(icode_i) || is_rd_op(icode_i);
    wdata_o  = val_a_i;
    // Stack pops read from the old stack pointer carried in valA.
    if ((icode_i == IPOPQ) || (icode_i == IRET)) begin
      addr_o = val_a_i[ADDR_W-1:0];
    end else begin
      addr_o = val_e_i;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data memory access controller with ack timeout; optional
// alignment trap when DMEM_ALIGN_CHECK_EN is defined.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              M_valid_i,
  input  logic [3:0]        M_icode_i,
  input  logic [ADDR_W-1:0] M_valE_i,
  input  logic [DATA_W-1:0] M_valA_i,
  input  logic [2:0]        M_stat_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic              dmem_err_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_valM_o,
  output logic [2:0]        m_stat_o,
  output logic              m_stall_o
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] valm_q, valm_d;
  logic [2:0]        stat_q, stat_d;

  logic              dec_mem, dec_we, misalign;
  logic [ADDR_W-1:0] dec_addr;
  logic [DATA_W-1:0] dec_wdata;

  dmem_op_decode #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dec (
    .icode_i  (M_icode_i),
    .val_e_i  (M_valE_i),
    .val_a_i  (M_valA_i),
    .is_mem_o (dec_mem),
    .we_o     (dec_we),
    .addr_o   (dec_addr),
    .wdata_o  (dec_wdata)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  localparam int ALIGN_W = $clog2(DATA_W / 8);
  assign misalign = |dec_addr[ALIGN_W-1:0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    valid_d   = 1'b0;
    valm_d    = valm_q;
    stat_d    = stat_q;
    m_stall_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (M_valid_i) begin
          if (!dec_mem || (M_stat_i != SAOK)) begin
            valid_d = 1'b1;
            valm_d  = '0;
            stat_d  = M_stat_i;
          end else if (misalign) begin
            valid_d = 1'b1;
            valm_d  = '0;
            stat_d  = SADR;
          end else begin
            m_stall_o = 1'b1;
            state_d   = ST_BUSY;
            cnt_d     = '0;
            req_d     = 1'b1;
            we_d      = dec_we;
            addr_d    = dec_addr;
            wdata_d   = dec_wdata;
          end
        end
      end
      ST_BUSY: begin
        // Ack is checked first so a late ack in the final wait cycle still lands.
        if (dmem_ack_i) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          valm_d  = we_q ? '0 : dmem_rdata_i;
          stat_d  = dmem_err_i ? SADR : M_stat_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          valm_d  = '0;
          stat_d  = SADR;
        end else begin
          m_stall_o = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      valm_q  <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      valm_q  <= valm_d;
      stat_q  <= stat_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign m_valid_o    = valid_q;
  assign m_valM_o     = valm_q;
  assign m_stat_o     = stat_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed-vector bench for dmem_access_ctrl with hand-computed expectations.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int TO = 15;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          M_valid_i;
  logic [3:0]    M_icode_i;
  logic [AW-1:0] M_valE_i;
  logic [DW-1:0] M_valA_i;
  logic [2:0]    M_stat_i;
  logic          dmem_req_o, dmem_we_o;
  logic [AW-1:0] dmem_addr_o;
  logic [DW-1:0] dmem_wdata_o;
  logic          dmem_ack_i, dmem_err_i;
  logic [DW-1:0] dmem_rdata_i;
  logic          m_valid_o;
  logic [DW-1:0] m_valM_o;
  logic [2:0]    m_stat_o;
  logic          m_stall_o;

  int n_cmp = 0;
  int n_mis = 0;
  int stall_cnt;

  dmem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .M_valid_i    (M_valid_i),
    .M_icode_i    (M_icode_i),
    .M_valE_i     (M_valE_i),
    .M_valA_i     (M_valA_i),
    .M_stat_i     (M_stat_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_err_i   (dmem_err_i),
    .dmem_rdata_i (dmem_rdata_i),
    .m_valid_o    (m_valid_o),
    .m_valM_o     (m_valM_o),
    .m_stat_o     (m_stat_o),
    .m_stall_o    (m_stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0; M_valid_i = 1'b0; M_icode_i = INOP; M_valE_i = '0; M_valA_i = '0;
    M_stat_i = SAOK; dmem_ack_i = 1'b0; dmem_err_i = 1'b0; dmem_rdata_i = '0;
    #2;
    chk("rst_req", 64'(dmem_req_o), 64'd0);
    chk("rst_we", 64'(dmem_we_o), 64'd0);
    chk("rst_addr", dmem_addr_o, 64'd0);
    chk("rst_wdata", dmem_wdata_o, 64'd0);
    chk("rst_valid", 64'(m_valid_o), 64'd0);
    chk("rst_valm", m_valM_o, 64'd0);
    chk("rst_stat", 64'(m_stat_o), 64'd0);
    M_valid_i = 1'b1; M_icode_i = IMRMOVQ; M_valE_i = 64'h40;
    #1 chk("rst_stall_mem", 64'(m_stall_o), 64'd1);
    M_valid_i = 1'b0;
    #1 chk("rst_stall_idle", 64'(m_stall_o), 64'd0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick();
    chk("idle_valid", 64'(m_valid_o), 64'd0);
    chk("idle_req", 64'(dmem_req_o), 64'd0);

    // Write, ack in the first busy cycle.
    M_valid_i = 1'b1; M_icode_i = IRMMOVQ; M_valE_i = 64'h100; M_valA_i = 64'hDEAD;
    #1 chk("wr_stall0", 64'(m_stall_o), 64'd1);
    tick();
    chk("wr_req", 64'(dmem_req_o), 64'd1);
    chk("wr_we", 64'(dmem_we_o), 64'd1);
    chk("wr_addr", dmem_addr_o, 64'h100);
    chk("wr_wdata", dmem_wdata_o, 64'hDEAD);
    chk("wr_valid_early", 64'(m_valid_o), 64'd0);
    dmem_ack_i = 1'b1;
    #1 chk("wr_stall_ack", 64'(m_stall_o), 64'd0);
    tick();
    chk("wr_valid", 64'(m_valid_o), 64'd1);
    chk("wr_stat", 64'(m_stat_o), 64'(SAOK));
    chk("wr_valm", m_valM_o, 64'd0);
    chk("wr_req_drop", 64'(dmem_req_o), 64'd0);
    M_valid_i = 1'b0; dmem_ack_i = 1'b0;
    tick();
    chk("wr_pulse_end", 64'(m_valid_o), 64'd0);
    chk("wr_stat_hold", 64'(m_stat_o), 64'(SAOK));

    // Pop, ack in the fourth busy cycle; junk rdata/err before ack is ignored.
    M_valid_i = 1'b1; M_icode_i = IPOPQ; M_valE_i = 64'h999; M_valA_i = 64'h200;
    stall_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        dmem_ack_i = 1'b1; dmem_rdata_i = 64'h55; dmem_err_i = 1'b0;
      end else if (i > 0) begin
        dmem_rdata_i = 64'hBAD; dmem_err_i = 1'b1;
      end
      #1;
      if (m_stall_o) stall_cnt++;
      tick();
      if (i == 0) begin
        chk("pop_addr", dmem_addr_o, 64'h200);
        chk("pop_we", 64'(dmem_we_o), 64'd0);
      end
      if (i < 4) chk("pop_no_valid", 64'(m_valid_o), 64'd0);
    end
    chk("pop_valid", 64'(m_valid_o), 64'd1);
    chk("pop_valm", m_valM_o, 64'h55);
    chk("pop_stat", 64'(m_stat_o), 64'(SAOK));
    chk("pop_stall_cycles", 64'(stall_cnt), 64'd4);
    M_valid_i = 1'b0; dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
    tick();
    chk("pop_valm_hold", m_valM_o, 64'h55);

    // Read with no ack: timeout abort, then a following instruction completes.
    M_valid_i = 1'b1; M_icode_i = IMRMOVQ; M_valE_i = 64'h300;
    tick();
    for (int k = 0; k < TO; k++) begin
      chk("to_req_held", 64'(dmem_req_o), 64'd1);
      chk("to_no_valid", 64'(m_valid_o), 64'd0);
      #1;
      if (k == TO - 1) chk("to_stall_last", 64'(m_stall_o), 64'd0);
      else if (k == TO - 2) chk("to_stall_prev", 64'(m_stall_o), 64'd1);
      tick();
    end
    chk("to_valid", 64'(m_valid_o), 64'd1);
    chk("to_stat", 64'(m_stat_o), 64'(SADR));
    chk("to_valm", m_valM_o, 64'd0);
    chk("to_req_drop", 64'(dmem_req_o), 64'd0);
    M_icode_i = IOPQ;
    #1 chk("to_next_stall", 64'(m_stall_o), 64'd0);
    tick();
    chk("to_next_valid", 64'(m_valid_o), 64'd1);
    chk("to_next_stat", 64'(m_stat_o), 64'(SAOK));

    // Call with bus error, then non-memory and memory ops with bad status.
    M_icode_i = ICALL; M_valE_i = 64'h400; M_valA_i = 64'h77;
    tick();
    chk("call_we", 64'(dmem_we_o), 64'd1);
    chk("call_addr", dmem_addr_o, 64'h400);
    chk("call_wdata", dmem_wdata_o, 64'h77);
    dmem_ack_i = 1'b1; dmem_err_i = 1'b1;
    tick();
    chk("call_valid", 64'(m_valid_o), 64'd1);
    chk("call_stat", 64'(m_stat_o), 64'(SADR));
    dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
    M_icode_i = IOPQ; M_stat_i = SINS;
    #1 chk("sins_stall", 64'(m_stall_o), 64'd0);
    tick();
    chk("sins_valid", 64'(m_valid_o), 64'd1);
    chk("sins_stat", 64'(m_stat_o), 64'(SINS));
    chk("sins_req", 64'(dmem_req_o), 64'd0);
    M_icode_i = IMRMOVQ; M_stat_i = SHLT; M_valE_i = 64'h800;
    #1 chk("shlt_stall", 64'(m_stall_o), 64'd0);
    tick();
    chk("shlt_req", 64'(dmem_req_o), 64'd0);
    chk("shlt_stat", 64'(m_stat_o), 64'(SHLT));
    M_stat_i = SAOK;

    // Misaligned read.
    M_icode_i = IMRMOVQ; M_valE_i = 64'h103;
`ifdef DMEM_ALIGN_CHECK_EN
    #1 chk("mis_stall", 64'(m_stall_o), 64'd0);
    tick();
    chk("mis_req", 64'(dmem_req_o), 64'd0);
    chk("mis_valid", 64'(m_valid_o), 64'd1);
    chk("mis_stat", 64'(m_stat_o), 64'(SADR));
    chk("mis_valm", m_valM_o, 64'd0);
`else
    tick();
    chk("mis_req", 64'(dmem_req_o), 64'd1);
    chk("mis_addr", dmem_addr_o, 64'h103);
    chk("mis_we", 64'(dmem_we_o), 64'd0);
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'h12;
    tick();
    chk("mis_valid", 64'(m_valid_o), 64'd1);
    chk("mis_valm", m_valM_o, 64'h12);
    chk("mis_stat", 64'(m_stat_o), 64'(SAOK));
    dmem_ack_i = 1'b0;
`endif

    // Reset in the second busy cycle, then a push completes.
    M_icode_i = IMRMOVQ; M_valE_i = 64'h500;
    tick();
    tick();
    chk("rb_req_busy", 64'(dmem_req_o), 64'd1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("rb_req_drop", 64'(dmem_req_o), 64'd0);
    chk("rb_valid", 64'(m_valid_o), 64'd0);
    chk("rb_stat", 64'(m_stat_o), 64'd0);
    M_valid_i = 1'b0;
    tick();
    chk("rb_valid_hold", 64'(m_valid_o), 64'd0);
    #2 rst_n_i = 1'b1;
    tick();
    chk("rb_post_valid", 64'(m_valid_o), 64'd0);
    chk("rb_post_req", 64'(dmem_req_o), 64'd0);
    M_valid_i = 1'b1; M_icode_i = IPUSHQ; M_valE_i = 64'h600; M_valA_i = 64'hAB;
    tick();
    chk("push_req", 64'(dmem_req_o), 64'd1);
    chk("push_we", 64'(dmem_we_o), 64'd1);
    chk("push_addr", dmem_addr_o, 64'h600);
    chk("push_wdata", dmem_wdata_o, 64'hAB);
    dmem_ack_i = 1'b1;
    tick();
    chk("push_valid", 64'(m_valid_o), 64'd1);
    chk("push_stat", 64'(m_stat_o), 64'(SAOK));
    chk("push_valm", m_valM_o, 64'd0);
    M_valid_i = 1'b0; dmem_ack_i = 1'b0;
    tick();
    chk("push_pulse_end", 64'(m_valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
